// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the five-stage RISC-V core, with
// load-use hazard detection and a saturating bubble counter.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   valid_i                       ID stage holds a real instruction
//   RegWrite_i .. Branch_i        decoded control bits
//   ALUOp_i [1:0]                 ALU class (00 I/load, 01 store, 10 R, 11 branch)
//   RS1data_i, RS2data_i, Imm_i   operands and sign-extended immediate
//   funct_i [9:0]                 {funct7, funct3}
//   RS1addr_i, RS2addr_i, RDaddr_i register indices
//   flush_i                       squash the instruction entering EX
//   hold_i                        downstream freeze, register keeps contents
//   *_o                           registered copies of the inputs, valid_o
//   stall_o                       combinational stall request to PC and IF/ID
//   bubble_cnt_o [CNT_W-1:0]      bubbles inserted by flush or hazard since reset
module id_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic              ALUSrc_i,
  input  logic              Branch_i,
  input  logic [1:0]        ALUOp_i,
  input  logic [31:0]       RS1data_i,
  input  logic [31:0]       RS2data_i,
  input  logic [31:0]       Imm_i,
  input  logic [9:0]        funct_i,
  input  logic [4:0]        RS1addr_i,
  input  logic [4:0]        RS2addr_i,
  input  logic [4:0]        RDaddr_i,
  input  logic              flush_i,
  input  logic              hold_i,
  output logic              valid_o,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic              MemRead_o,
  output logic              MemWrite_o,
  output logic              ALUSrc_o,
  output logic              Branch_o,
  output logic [1:0]        ALUOp_o,
  output logic [31:0]       RS1data_o,
  output logic [31:0]       RS2data_o,
  output logic [31:0]       Imm_o,
  output logic [9:0]        funct_o,
  output logic [4:0]        RS1addr_o,
  output logic [4:0]        RS2addr_o,
  output logic [4:0]        RDaddr_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  bubble_cnt_o
);

  logic haz;
  logic squash;
  logic bubble;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  // Both source indices are compared regardless of opcode; a false stall on
  // an I-type instruction costs one cycle but never breaks correctness.
  assign haz = valid_o & MemRead_o & (RDaddr_o != 5'd0) & valid_i &
               ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i));

  assign stall_o = haz | hold_i;
  assign squash  = flush_i | haz;
  assign bubble  = squash | ~valid_i;

  // ---- EX stage boundary ----
  // A bubble zeroes every field so forwarding logic never matches a stale RDaddr_o.
  always_ff @(posedge clk_i) begin
    if (rst_i || (!hold_i && bubble)) begin
      valid_o    <= 1'b0;
      RegWrite_o <= 1'b0;
      MemtoReg_o <= 1'b0;
      MemRead_o  <= 1'b0;
      MemWrite_o <= 1'b0;
      ALUSrc_o   <= 1'b0;
      Branch_o   <= 1'b0;
      ALUOp_o    <= 2'b00;
      RS1data_o  <= '0;
      RS2data_o  <= '0;
      Imm_o      <= '0;
      funct_o    <= '0;
      RS1addr_o  <= '0;
      RS2addr_o  <= '0;
      RDaddr_o   <= '0;
    end else if (!hold_i) begin
      valid_o    <= 1'b1;
      RegWrite_o <= RegWrite_i;
      MemtoReg_o <= MemtoReg_i;
      MemRead_o  <= MemRead_i;
      MemWrite_o <= MemWrite_i;
      ALUSrc_o   <= ALUSrc_i;
      Branch_o   <= Branch_i;
      ALUOp_o    <= ALUOp_i;
      RS1data_o  <= RS1data_i;
      RS2data_o  <= RS2data_i;
      Imm_o      <= Imm_i;
      funct_o    <= funct_i;
      RS1addr_o  <= RS1addr_i;
      RS2addr_o  <= RS2addr_i;
      RDaddr_o   <= RDaddr_i;
    end
  end

  // Only flush- or hazard-induced bubbles count; idle cycles (!valid_i) do not,
  // and a simultaneous flush and hazard is still a single bubble.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
    end else if (!hold_i && squash) begin
      bubble_cnt_o <= sat_inc(bubble_cnt_o);
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

  localparam int CNT_W = 4;

  logic clk = 1'b0;
  logic rst, valid, regw, memtoreg, memread, memwrite, alusrc, branch, flush, hold;
  logic [1:0]  aluop;
  logic [31:0] rs1d, rs2d, imm;
  logic [9:0]  funct;
  logic [4:0]  rs1a, rs2a, rda;

  logic valid_q, regw_q, memtoreg_q, memread_q, memwrite_q, alusrc_q, branch_q, stall;
  logic [1:0]  aluop_q;
  logic [31:0] rs1d_q, rs2d_q, imm_q;
  logic [9:0]  funct_q;
  logic [4:0]  rs1a_q, rs2a_q, rda_q;
  logic [CNT_W-1:0] cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid),
    .RegWrite_i(regw), .MemtoReg_i(memtoreg), .MemRead_i(memread),
    .MemWrite_i(memwrite), .ALUSrc_i(alusrc), .Branch_i(branch),
    .ALUOp_i(aluop), .RS1data_i(rs1d), .RS2data_i(rs2d), .Imm_i(imm),
    .funct_i(funct), .RS1addr_i(rs1a), .RS2addr_i(rs2a), .RDaddr_i(rda),
    .flush_i(flush), .hold_i(hold),
    .valid_o(valid_q), .RegWrite_o(regw_q), .MemtoReg_o(memtoreg_q),
    .MemRead_o(memread_q), .MemWrite_o(memwrite_q), .ALUSrc_o(alusrc_q),
    .Branch_o(branch_q), .ALUOp_o(aluop_q), .RS1data_o(rs1d_q),
    .RS2data_o(rs2d_q), .Imm_o(imm_q), .funct_o(funct_q),
    .RS1addr_o(rs1a_q), .RS2addr_o(rs2a_q), .RDaddr_o(rda_q),
    .stall_o(stall), .bubble_cnt_o(cnt)
  );

  typedef struct {
    string       name;
    logic        rst, valid, flush, hold, regw, memread;
    logic [1:0]  aluop;
    logic [31:0] rs1d;
    logic [4:0]  rs1, rs2, rd;
    logic        chk_stall, e_stall;
    logic        e_valid, e_regw, e_memread;
    logic [1:0]  e_aluop;
    logic [31:0] e_rs1d;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic [3:0]  e_cnt;
  } vec_t;

  function automatic vec_t mk(
    input string nm, input logic r, v, f, h, rw, mr, input logic [1:0] op,
    input logic [31:0] d, input logic [4:0] s1, s2, d5,
    input logic cs, es, ev, erw, emr, input logic [1:0] eop,
    input logic [31:0] ed, input logic [4:0] es1, es2, erd, input logic [3:0] ec);
    vec_t t;
    t.name = nm; t.rst = r; t.valid = v; t.flush = f; t.hold = h;
    t.regw = rw; t.memread = mr; t.aluop = op; t.rs1d = d;
    t.rs1 = s1; t.rs2 = s2; t.rd = d5;
    t.chk_stall = cs; t.e_stall = es; t.e_valid = ev; t.e_regw = erw;
    t.e_memread = emr; t.e_aluop = eop; t.e_rs1d = ed;
    t.e_rs1 = es1; t.e_rs2 = es2; t.e_rd = erd; t.e_cnt = ec;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // The secondary fields are encoded from the primary ones so one row fully
  // specifies every port.
  task automatic drive(input vec_t t);
    rst = t.rst; valid = t.valid; flush = t.flush; hold = t.hold;
    regw = t.regw; memread = t.memread; memtoreg = t.memread; alusrc = t.memread;
    aluop = t.aluop; memwrite = (t.aluop == 2'b01); branch = (t.aluop == 2'b11);
    rs1d = t.rs1d; rs2d = t.rs1d ^ 32'hFFFF_0000; imm = t.rs1d + 32'd1;
    funct = {5'b0, t.rd}; rs1a = t.rs1; rs2a = t.rs2; rda = t.rd;
  endtask

  task automatic check_outputs(input vec_t t);
    logic [31:0] z;
    z = {31'b0, t.e_valid};
    chk({t.name, ".valid_o"},    {31'b0, valid_q},    z);
    chk({t.name, ".RegWrite_o"}, {31'b0, regw_q},     {31'b0, t.e_regw});
    chk({t.name, ".MemRead_o"},  {31'b0, memread_q},  {31'b0, t.e_memread});
    chk({t.name, ".MemtoReg_o"}, {31'b0, memtoreg_q}, {31'b0, t.e_memread});
    chk({t.name, ".ALUSrc_o"},   {31'b0, alusrc_q},   {31'b0, t.e_memread});
    chk({t.name, ".MemWrite_o"}, {31'b0, memwrite_q}, {31'b0, t.e_valid && t.e_aluop == 2'b01});
    chk({t.name, ".Branch_o"},   {31'b0, branch_q},   {31'b0, t.e_valid && t.e_aluop == 2'b11});
    chk({t.name, ".ALUOp_o"},    {30'b0, aluop_q},    {30'b0, t.e_aluop});
    chk({t.name, ".RS1data_o"},  rs1d_q, t.e_rs1d);
    chk({t.name, ".RS2data_o"},  rs2d_q, t.e_valid ? (t.e_rs1d ^ 32'hFFFF_0000) : 32'h0);
    chk({t.name, ".Imm_o"},      imm_q,  t.e_valid ? (t.e_rs1d + 32'd1) : 32'h0);
    chk({t.name, ".funct_o"},    {22'b0, funct_q}, t.e_valid ? {27'b0, t.e_rd} : 32'h0);
    chk({t.name, ".RS1addr_o"},  {27'b0, rs1a_q}, {27'b0, t.e_rs1});
    chk({t.name, ".RS2addr_o"},  {27'b0, rs2a_q}, {27'b0, t.e_rs2});
    chk({t.name, ".RDaddr_o"},   {27'b0, rda_q},  {27'b0, t.e_rd});
    chk({t.name, ".bubble_cnt"}, {28'b0, cnt},    {28'b0, t.e_cnt});
  endtask

  vec_t vecs[$];

  initial begin
    //            name          rst v f h rw mr op     rs1d           s1 s2 rd  cs es  ev rw mr eop    e_rs1d       e1 e2 erd cnt
    vecs.push_back(mk("reset_a",  1,1,1,0,1,1,2'b00,32'hDEAD_BEEF,7,7,7, 0,0, 0,0,0,2'b00,32'h0,     0,0,0, 0));
    vecs.push_back(mk("reset_b",  1,1,0,0,1,0,2'b10,32'hCAFE_0001,3,4,5, 1,0, 0,0,0,2'b00,32'h0,     0,0,0, 0));
    vecs.push_back(mk("pass_r",   0,1,0,0,1,0,2'b10,32'h1234,     1,2,5, 1,0, 1,1,0,2'b10,32'h1234,  1,2,5, 0));
    vecs.push_back(mk("load_x7",  0,1,0,0,1,1,2'b00,32'h100,      5,0,7, 1,0, 1,1,1,2'b00,32'h100,   5,0,7, 0));
    vecs.push_back(mk("use_x7",   0,1,0,0,1,0,2'b10,32'hAAAA,     3,7,8, 1,1, 0,0,0,2'b00,32'h0,     0,0,0, 1));
    vecs.push_back(mk("use_go",   0,1,0,0,1,0,2'b10,32'hAAAA,     3,7,8, 1,0, 1,1,0,2'b10,32'hAAAA,  3,7,8, 1));
    vecs.push_back(mk("load_x0",  0,1,0,0,1,1,2'b00,32'h40,       8,9,0, 1,0, 1,1,1,2'b00,32'h40,    8,9,0, 1));
    vecs.push_back(mk("rs1_x0",   0,1,0,0,1,0,2'b10,32'h55,       0,0,7, 1,0, 1,1,0,2'b10,32'h55,    0,0,7, 1));
    vecs.push_back(mk("alu_rd7",  0,1,0,0,1,0,2'b10,32'h66,       7,1,2, 1,0, 1,1,0,2'b10,32'h66,    7,1,2, 1));
    vecs.push_back(mk("flush",    0,1,1,0,1,0,2'b10,32'h77,       4,4,3, 1,0, 0,0,0,2'b00,32'h0,     0,0,0, 2));
    vecs.push_back(mk("invalid",  0,0,0,0,1,0,2'b10,32'h77,       4,4,3, 1,0, 0,0,0,2'b00,32'h0,     0,0,0, 2));
    vecs.push_back(mk("load_x6",  0,1,0,0,1,1,2'b00,32'h88,       1,1,6, 1,0, 1,1,1,2'b00,32'h88,    1,1,6, 2));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk("hold",   0,1,1,1,0,0,2'b10,32'h99,       6,0,4, 1,1, 1,1,1,2'b00,32'h88,    1,1,6, 2));
    vecs.push_back(mk("flush_haz",0,1,1,0,0,0,2'b10,32'h99,       6,0,4, 1,1, 0,0,0,2'b00,32'h0,     0,0,0, 3));
    vecs.push_back(mk("load_x6b", 0,1,0,0,1,1,2'b00,32'h111,      1,2,6, 1,0, 1,1,1,2'b00,32'h111,   1,2,6, 3));
    vecs.push_back(mk("rst_stall",1,1,0,0,1,0,2'b10,32'h222,      0,6,9, 1,1, 0,0,0,2'b00,32'h0,     0,0,0, 0));
    vecs.push_back(mk("hold_zero",0,1,0,1,1,0,2'b10,32'h222,      0,6,9, 1,1, 0,0,0,2'b00,32'h0,     0,0,0, 0));
    vecs.push_back(mk("idle",     0,0,0,0,1,0,2'b10,32'h222,      0,6,9, 1,0, 0,0,0,2'b00,32'h0,     0,0,0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i]);
      #1;
      if (vecs[i].chk_stall)
        chk({vecs[i].name, ".stall_o"}, {31'b0, stall}, {31'b0, vecs[i].e_stall});
      @(posedge clk);
      #1;
      check_outputs(vecs[i]);
      @(negedge clk);
    end

    // Saturation: 20 consecutive flushes on a 4-bit counter end at 15.
    flush = 1'b1; valid = 1'b1; hold = 1'b0; rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      chk("sat.bubble_cnt", {28'b0, cnt}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
      chk("sat.valid_o", {31'b0, valid_q}, 32'd0);
      @(negedge clk);
    end
    flush = 1'b0;
    @(posedge clk);
    #1;
    chk("sat.final_cnt", {28'b0, cnt}, 32'd15);
    chk("sat.resume_valid", {31'b0, valid_q}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the five-stage RISC-V core. It sits directly downstream of the instruction decoder's `Control` unit and the register file. It captures their outputs on each clock and presents them to the EX stage. It also detects load-use hazards against the instruction already in EX: on a hazard it inserts a bubble and raises a stall request to the PC and IF/ID stages.

## Interface
Parameters:
- `CNT_W`, default 16: width of the saturating bubble counter.

Ports:
- `clk_i` in 1: the single clock. All state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `valid_i` in 1: the ID stage holds a real instruction.
- `RegWrite_i`, `MemtoReg_i`, `MemRead_i`, `MemWrite_i`, `ALUSrc_i`, `Branch_i` in 1 each: decoded control bits.
- `ALUOp_i` in 2: ALU operation class (00 I/load, 01 store, 10 R, 11 branch).
- `RS1data_i`, `RS2data_i`, `Imm_i` in 32 each: operand data and sign-extended immediate.
- `funct_i` in 10: {funct7, funct3}.
- `RS1addr_i`, `RS2addr_i`, `RDaddr_i` in 5 each: register indices.
- `flush_i` in 1: squash the instruction entering EX, e.g. a taken branch.
- `hold_i` in 1: downstream freeze. The register keeps its contents.
- `*_o` out: registered copies of every `*_i` above (same widths), plus `valid_o` out 1.
- `stall_o` out 1: combinational. Hold PC and IF/ID, and keep ID inputs stable.
- `bubble_cnt_o` out `CNT_W`: number of bubbles inserted since reset.

## Operation
- Hazard term: `haz = valid_o & MemRead_o & (RDaddr_o != 0) & valid_i & ((RDaddr_o == RS1addr_i) | (RDaddr_o == RS2addr_i))`.
  - Both sources are compared for every opcode. False stalls on I-type instructions are accepted.
- `stall_o = haz | hold_i`.
- Next-state priority, evaluated each rising edge:
  1. `rst_i`: all outputs and the counter go to 0.
  2. `hold_i`: every register keeps its value. The counter also holds, even if `flush_i` or `haz` is active.
  3. `flush_i`: bubble.
  4. `haz`: bubble.
  5. `!valid_i`: bubble, and the counter is not incremented.
  6. Otherwise: load every `*_i` into its `*_o` and set `valid_o` = 1.
- Bubble: `valid_o`, `RegWrite_o`, `MemtoReg_o`, `MemRead_o`, `MemWrite_o`, `Branch_o`, `ALUSrc_o` = 0 and `ALUOp_o` = 00.
  - Data, address and funct fields are zeroed as well, so downstream forwarding never sees stale `RDaddr_o`.
- Counter: increments by 1 on each bubble caused by `flush_i` or `haz`. It saturates at all-ones and never wraps.
- No other state. The block has no internal FSM beyond the pipeline register and the counter.

## Timing
- Latency: 1 cycle from input to `*_o`.
- `stall_o` is combinational from `*_o` and the ID inputs. It is valid in the same cycle. No registered delay.
- Load-use sequence:
  - Cycle N: load in EX, dependent instruction in ID, `haz` = 1.
  - Edge N+1: bubble enters EX, and the ID inputs are held upstream.
  - Cycle N+1: `haz` = 0 because `valid_o` = 0.
  - Edge N+2: the dependent instruction loads.
  - Total: exactly one bubble per load-use pair.
- `flush_i` together with `haz`: one bubble, counter +1 (not +2).
- Reset during a stall: reset wins. Next cycle all outputs are 0 and `stall_o` = `hold_i`.
- `rst_i` held high: outputs stay 0 regardless of the other inputs.

## Test plan
- Reset: assert `rst_i` 2 cycles with random inputs. Check all `*_o` = 0 and `bubble_cnt_o` = 0. Check `stall_o` = 0 when `hold_i` = 0.
- Passthrough: valid R-type (`RegWrite_i`=1, `ALUOp_i`=10, `RDaddr_i`=5, `RS1data_i`=0x1234). Next cycle check these appear on `*_o` and `valid_o` = 1. Check `stall_o` = 0 throughout.
- Load-use: load with rd=x7 registered. Then ID presents `RS2addr_i`=7. Check `stall_o`=1 the same cycle. Next cycle check a bubble (`valid_o`=0, `RegWrite_o`=0), `bubble_cnt_o`=1 and `stall_o`=0. Following cycle check the dependent instruction appears.
- x0 and non-load: load with rd=x0 and `RS1addr_i`=0 gives no stall. An ALU op with rd=x7 and `RS1addr_i`=7 gives no stall.
- Flush and hold:
  - `flush_i`=1 with a valid input gives a bubble, counter +1.
  - `hold_i`=1 for 3 cycles freezes all outputs and the counter, with `stall_o`=1.
  - `flush_i` with `haz` in the same cycle gives counter +1 only.
- Saturation: with `CNT_W`=4, force 20 flush cycles. Check `bubble_cnt_o` = 15 and no wrap.
